viterbi_decoder_rx: RTL and testbench

- Parametrised successor to the receiver's first Viterbi decoder.
- Hard-decision, K=7, rate-1/2 decoder using the 802.11a generator polynomials g0=133 (octal) and g1=171 (octal).
- Accepts depunctured symbol pairs with per-bit erasure flags, so it serves rates 1/2, 2/3 and 3/4.
- Uses register-exchange survivors with a parametrised window, per-frame flush on a terminated trellis, and metric normalisation. Sits between the deinterleaver/depuncturer and the descrambler.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_acs.sv | 23 ++
 rtl/viterbi_decoder_rx.sv | 147 ++++++++++++++
 tb/tb_viterbi_decoder_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=7, rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned NUM_STATES = 64;
  localparam logic [6:0]  G0         = 7'o133;
  localparam logic [6:0]  G1         = 7'o171;

  typedef enum logic {RUN, FLUSH} fsm_t;

  // Returns {A, B}; generator MSB taps the current input bit, LSB the oldest state bit.
  function automatic logic [1:0] enc_out(input logic [5:0] state, input logic b);
    logic [6:0] taps;
    taps = {b, state[0], state[1], state[2], state[3], state[4], state[5]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to predecessor 0.
module viterbi_acs #(
  parameter int unsigned METRIC_W = 8
) (
  input  logic [METRIC_W-1:0] PredMetric0,
  input  logic [METRIC_W-1:0] PredMetric1,
  input  logic [1:0]          BranchMetric0,
  input  logic [1:0]          BranchMetric1,
  output logic [METRIC_W-1:0] NewMetric,
  output logic                Select
);

  logic [METRIC_W:0] sum0;
  logic [METRIC_W:0] sum1;

  always_comb begin
    sum0      = {1'b0, PredMetric0} + {{(METRIC_W-1){1'b0}}, BranchMetric0};
    sum1      = {1'b0, PredMetric1} + {{(METRIC_W-1){1'b0}}, BranchMetric1};
    Select    = (sum1 < sum0);
    NewMetric = Select ? sum1[METRIC_W-1:0] : sum0[METRIC_W-1:0];
  end

endmodule

// File: rtl/viterbi_decoder_rx.sv
// Hard-decision K=7 Viterbi decoder with register-exchange survivors, erasure-aware
// branch metrics and per-frame flush of a terminated trellis.
module viterbi_decoder_rx
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH     = 42,
  parameter int unsigned METRIC_W     = 8,
  parameter int unsigned INIT_PENALTY = 2**(METRIC_W-2)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  output logic       InReady,
  input  logic [1:0] InBits,
  input  logic [1:0] InErase,
  input  logic       InLast,
  output logic       OutValid,
  output logic       Output,
  output logic       OutLast
);

  localparam int unsigned         KW      = $clog2(TB_DEPTH + 1);
  localparam logic [KW-1:0]       DEPTH_K = KW'(TB_DEPTH);
  localparam logic [METRIC_W-1:0] PENALTY = METRIC_W'(INIT_PENALTY);

  fsm_t                state;
  logic [KW-1:0]       k;
  logic [KW-1:0]       pending;
  logic [METRIC_W-1:0] metric [NUM_STATES];
  logic [TB_DEPTH-1:0] surv   [NUM_STATES];

  logic [METRIC_W-1:0]   acs_metric  [NUM_STATES];
  logic [METRIC_W-1:0]   next_metric [NUM_STATES];
  logic [TB_DEPTH-1:0]   next_surv   [NUM_STATES];
  logic [NUM_STATES-1:0] acs_sel;
  logic [NUM_STATES-1:0] msb_vec;
  logic                  all_msb;
  logic [5:0]            best;
  logic [KW-1:0]         k_new;
  logic                  accept;

  function automatic logic [1:0] branch_metric(input logic [1:0] code_bits,
                                               input logic [1:0] rx_bits,
                                               input logic [1:0] erase);
    logic [1:0] diff;
    diff = (code_bits ^ rx_bits) & ~erase;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  assign accept  = InValid & InReady;
  assign all_msb = &msb_vec;
  // k saturates at TB_DEPTH, so k_new is already min(k_new, TB_DEPTH) for the flush count.
  assign k_new   = (k == DEPTH_K) ? k : k + 1'b1;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [5:0] NS = 6'(s);
    localparam logic [5:0] P0 = {1'b0, NS[5:1]};
    localparam logic [5:0] P1 = {1'b1, NS[5:1]};
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branch_metric(enc_out(P0, NS[0]), InBits, InErase);
    assign bm1 = branch_metric(enc_out(P1, NS[0]), InBits, InErase);

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
      .PredMetric0  (metric[P0]),
      .PredMetric1  (metric[P1]),
      .BranchMetric0(bm0),
      .BranchMetric1(bm1),
      .NewMetric    (acs_metric[s]),
      .Select       (acs_sel[s])
    );

    assign msb_vec[s]     = acs_metric[s][METRIC_W-1];
    assign next_metric[s] = {acs_metric[s][METRIC_W-1] & ~all_msb, acs_metric[s][METRIC_W-2:0]};
    assign next_surv[s]   = {acs_sel[s] ? surv[P1][TB_DEPTH-2:0] : surv[P0][TB_DEPTH-2:0], NS[0]};
  end

  // Uniform MSB clearing keeps ordering, so the search can use pre-normalisation metrics.
  always_comb begin
    best = '0;
    for (int unsigned i = 1; i < NUM_STATES; i++) begin
      if (acs_metric[i] < acs_metric[best]) best = 6'(i);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= RUN;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Output   <= 1'b0;
      OutLast  <= 1'b0;
      k        <= '0;
      pending  <= '0;
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        metric[i] <= (i == 0) ? '0 : PENALTY;
        surv[i]   <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          OutValid <= 1'b0;
          OutLast  <= 1'b0;
          if (accept) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
              metric[i] <= next_metric[i];
              surv[i]   <= next_surv[i];
            end
            k <= k_new;
            if (InLast) begin
              // The first flush bit leaves on the InLast edge; pending counts the rest.
              state    <= FLUSH;
              InReady  <= 1'b0;
              OutValid <= 1'b1;
              Output   <= next_surv[0][k_new - 1'b1];
              OutLast  <= (k_new == KW'(1));
              pending  <= k_new - 1'b1;
            end else if (k_new == DEPTH_K) begin
              OutValid <= 1'b1;
              Output   <= next_surv[best][TB_DEPTH-1];
            end
          end
        end
        FLUSH: begin
          if (pending == '0) begin
            state    <= RUN;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            k        <= '0;
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
              metric[i] <= (i == 0) ? '0 : PENALTY;
            end
          end else begin
            OutValid <= 1'b1;
            Output   <= surv[0][pending - 1'b1];
            OutLast  <= (pending == KW'(1));
            pending  <= pending - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_rx.sv
// Directed bench: encodes known frames, feeds the decoder and checks decoded bits and framing.
module tb_viterbi_decoder_rx;

  localparam int unsigned DEPTH = 42;
  localparam int unsigned MW    = 6;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [1:0] InBits;
  logic [1:0] InErase;
  logic       InLast;
  logic       OutValid;
  logic       Output;
  logic       OutLast;

  viterbi_decoder_rx #(.TB_DEPTH(DEPTH), .METRIC_W(MW)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .InValid (InValid),
    .InReady (InReady),
    .InBits  (InBits),
    .InErase (InErase),
    .InLast  (InLast),
    .OutValid(OutValid),
    .Output  (Output),
    .OutLast (OutLast)
  );

  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  bit          exp_q[$];
  bit          out_q[$];
  int          last_pos[$];
  int          acc_cnt, offer_blocked, ready_low, slide_cnt, first_out_acc, norm_events;
  int unsigned cur_min;
  int unsigned prev_min = 0;
  logic        prev_ready = 1'b0;
  logic [31:0] rng = 32'h1234_5678;
  logic [5:0]  enc_st;

  always @(posedge Clock) begin
    if (!Reset && InValid) begin
      if (InReady) acc_cnt++;
      else offer_blocked++;
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      if (OutValid) begin
        out_q.push_back(Output);
        if (first_out_acc < 0) first_out_acc = acc_cnt;
        if (InReady) slide_cnt++;
        if (OutLast) last_pos.push_back(out_q.size());
      end
      if (!InReady) ready_low++;
      cur_min = 1000;
      for (int i = 0; i < 64; i++) begin
        if (dut.metric[i] < cur_min) cur_min = dut.metric[i];
      end
      // Within RUN the minimum metric only ever drops through normalisation.
      if (prev_ready && InReady && cur_min < prev_min) norm_events++;
      prev_min   = cur_min;
      prev_ready = InReady;
    end
  end

  task automatic check(input string tag, input int obs, input int want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic clear();
    exp_q.delete();
    out_q.delete();
    last_pos.delete();
    acc_cnt       = 0;
    offer_blocked = 0;
    ready_low     = 0;
    slide_cnt     = 0;
    first_out_acc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  function automatic int last_at(input int idx);
    return (last_pos.size() > idx) ? last_pos[idx] : -1;
  endfunction

  // n_data random bits plus a 6-bit zero tail; optional A-bit flips, 3/4 puncturing,
  // one fully erased symbol, and early abort (no InLast) after abort_at symbols.
  task automatic drive_frame(input int n_data, input int err_period, input bit punct,
                             input int both_erase, input int abort_at);
    int         n;
    int         guard;
    bit         b;
    logic [1:0] code;
    logic [1:0] er;
    n      = n_data + 6;
    enc_st = '0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      if (i < n_data) begin
        rng = rng ^ (rng << 13);
        rng = rng ^ (rng >> 17);
        rng = rng ^ (rng << 5);
        b   = rng[0];
      end else begin
        b = 1'b0;
      end
      exp_q.push_back(b);
      code[1] = b ^ enc_st[1] ^ enc_st[2] ^ enc_st[4] ^ enc_st[5];
      code[0] = b ^ enc_st[0] ^ enc_st[1] ^ enc_st[2] ^ enc_st[5];
      enc_st  = {enc_st[4:0], b};
      if (err_period > 0 && (i + 1) % err_period == 0) code[1] = ~code[1];
      er = 2'b00;
      if (punct) er = (i % 3 == 1) ? 2'b01 : ((i % 3 == 2) ? 2'b10 : 2'b00);
      if (i == both_erase) er = 2'b11;
      InValid = 1'b1;
      InBits  = code & ~er;
      InErase = er;
      InLast  = (i == n - 1);
      guard   = 0;
      while (!InReady && guard < 200) begin
        @(posedge Clock);
        #1;
        guard++;
      end
      if (!InReady) check("ready_timeout", int'(InReady), 1);
      @(posedge Clock);
      #1;
    end
    InLast = 1'b0;
  endtask

  task automatic wait_last(input int n);
    int guard;
    guard = 0;
    while (last_pos.size() < n && guard < 3000) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    check("outlast_seen", last_pos.size(), n);
    idle(2);
  endtask

  task automatic compare(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      if (out_q[i] != exp_q[i]) mism++;
    end
    check({tag, "_count"}, out_q.size(), exp_q.size());
    check({tag, "_bits"}, mism, 0);
  endtask

  initial begin
    Reset   = 1'b1;
    InValid = 1'b0;
    InBits  = 2'b00;
    InErase = 2'b00;
    InLast  = 1'b0;
    clear();
    norm_events = 0;
    idle(2);
    check("rst_inready", int'(InReady), 1);
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_output", int'(Output), 0);
    check("rst_outlast", int'(OutLast), 0);
    check("rst_metric0", int'(dut.metric[0]), 0);
    check("rst_metric1", int'(dut.metric[1]), 16);
    check("rst_metric63", int'(dut.metric[63]), 16);
    Reset = 1'b0;
    idle(2);

    // Short error-free frame: everything comes out of the flush.
    clear();
    drive_frame(24, 0, 1'b0, -1, -1);
    InValid = 1'b0;
    wait_last(1);
    compare("short30");
    check("short30_first_after_acc", first_out_acc, 30);
    check("short30_sliding", slide_cnt, 0);
    check("short30_lastpos", last_at(0), 30);
    check("short30_ready_low", ready_low, 30);

    // Long frame with one coded-bit error every 20 symbols.
    clear();
    drive_frame(294, 20, 1'b0, -1, -1);
    InValid = 1'b0;
    wait_last(1);
    compare("long300");
    check("long300_first_after_acc", first_out_acc, 42);
    check("long300_sliding", slide_cnt, 258);
    check("long300_lastpos", last_at(0), 300);

    // Rate 3/4 puncturing with one fully erased symbol.
    clear();
    drive_frame(84, 0, 1'b1, 40, -1);
    InValid = 1'b0;
    wait_last(1);
    compare("punct90");
    check("punct90_lastpos", last_at(0), 90);

    // Enough errors to push the 6-bit metrics through normalisation.
    clear();
    norm_events = 0;
    drive_frame(794, 20, 1'b0, -1, -1);
    InValid = 1'b0;
    wait_last(1);
    compare("norm800");
    check("norm800_normalised", int'(norm_events > 0), 1);

    // Reset after 50 symbols of an unfinished frame.
    clear();
    drive_frame(94, 0, 1'b0, -1, 50);
    InValid = 1'b0;
    Reset   = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("midrst_outvalid", int'(OutValid), 0);
    check("midrst_inready", int'(InReady), 1);
    check("midrst_metric0", int'(dut.metric[0]), 0);
    check("midrst_metric1", int'(dut.metric[1]), 16);
    check("midrst_metric40", int'(dut.metric[40]), 16);
    check("midrst_no_outlast", last_pos.size(), 0);
    clear();
    drive_frame(4, 0, 1'b0, -1, -1);
    InValid = 1'b0;
    wait_last(1);
    compare("post_rst10");
    check("post_rst10_lastpos", last_at(0), 10);

    // Back-to-back frames: the second is offered throughout the first one's flush.
    clear();
    drive_frame(1, 0, 1'b0, -1, -1);
    drive_frame(6, 0, 1'b0, -1, -1);
    InValid = 1'b0;
    wait_last(2);
    compare("b2b");
    check("b2b_lastpos0", last_at(0), 7);
    check("b2b_lastpos1", last_at(1), 19);
    check("b2b_blocked", offer_blocked, 7);
    check("b2b_accepted", acc_cnt, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
